// File: rtl/gate_array_pipe.sv
// Bitwise gate-function pipeline: applies one of eight gate ops across a WIDTH-bit pair
// and carries the result through STAGES valid/ready register stages, with parity and a handshake counter.
module gate_array_pipe #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             parity,
  output logic [15:0]      xfer_count
);

  function automatic logic [WIDTH-1:0] gate_fn(input logic [2:0]       sel,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] z);
    case (sel)
      3'd0:    gate_fn = x & z;
      3'd1:    gate_fn = x | z;
      3'd2:    gate_fn = x ^ z;
      3'd3:    gate_fn = ~(x & z);
      3'd4:    gate_fn = ~(x | z);
      3'd5:    gate_fn = ~(x ^ z);
      3'd6:    gate_fn = ~x;
      default: gate_fn = x;
    endcase
  endfunction

  function automatic logic parity_fn(input logic [WIDTH-1:0] v);
    parity_fn = ^v;
  endfunction

  logic [STAGES-1:0] vld_q;
  logic [WIDTH-1:0]  y_q    [STAGES];
  logic [STAGES-1:0] load;
  logic              hole;
  logic [STAGES-1:0] up_vld;
  logic [WIDTH-1:0]  up_y   [STAGES];
  logic [15:0]       cnt_q;
  logic [15:0]       cnt_d;

  // Stage k may load when out_ready is high or any stage at or after k is empty.
  always_comb begin
    hole = 1'b0;
    load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      hole    = hole | ~vld_q[k];
      load[k] = out_ready | hole;
    end
  end

  always_comb begin
    up_vld    = '0;
    up_vld[0] = in_valid;
    up_y[0]   = gate_fn(op, a, b);
    for (int k = 1; k < STAGES; k++) begin
      up_vld[k] = vld_q[k-1];
      up_y[k]   = y_q[k-1];
    end
  end

  assign cnt_d      = cnt_q + 16'd1;
  assign in_ready   = load[0];
  assign out_valid  = vld_q[STAGES-1];
  assign y          = y_q[STAGES-1];
  assign parity     = parity_fn(y_q[STAGES-1]);
  assign xfer_count = cnt_q;

  // Pipeline stage registers: data only moves on a valid transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      cnt_q <= '0;
      for (int k = 0; k < STAGES; k++) y_q[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          vld_q[k] <= up_vld[k];
          if (up_vld[k]) y_q[k] <= up_y[k];
        end
      end
      if (out_valid && out_ready) cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_gate_array_pipe.sv
// Scoreboard bench for gate_array_pipe at three parameter points (4/2, 1/1, 64/4).
module tb_gate_array_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  logic        iv_a, ir_a, ov_a, or_a, par_a;
  logic [2:0]  op_a;
  logic [3:0]  a_a, b_a, y_a;
  logic [15:0] cnt_a;

  logic        iv_b, ir_b, ov_b, or_b, par_b;
  logic [2:0]  op_b;
  logic [0:0]  a_b, b_b, y_b;
  logic [15:0] cnt_b;

  logic        iv_c, ir_c, ov_c, or_c, par_c;
  logic [2:0]  op_c;
  logic [63:0] a_c, b_c, y_c;
  logic [15:0] cnt_c;

  gate_array_pipe #(.WIDTH(4), .STAGES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir_a), .op(op_a), .a(a_a), .b(b_a),
    .out_valid(ov_a), .out_ready(or_a), .y(y_a), .parity(par_a), .xfer_count(cnt_a));

  gate_array_pipe #(.WIDTH(1), .STAGES(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b), .op(op_b), .a(a_b), .b(b_b),
    .out_valid(ov_b), .out_ready(or_b), .y(y_b), .parity(par_b), .xfer_count(cnt_b));

  gate_array_pipe #(.WIDTH(64), .STAGES(4)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_c), .in_ready(ir_c), .op(op_c), .a(a_c), .b(b_c),
    .out_valid(ov_c), .out_ready(or_c), .y(y_c), .parity(par_c), .xfer_count(cnt_c));

  // a=1100, b=1010 for ops 0..7
  logic [3:0] sweep_y [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b0011, 4'b1100};
  logic       sweep_p [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  // a=1, b=0 for ops 0..7 (WIDTH=1, parity equals y)
  logic       b_tab   [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  logic [4:0]  q_a [$];
  logic [1:0]  q_b [$];
  logic [64:0] q_c [$];
  logic [4:0]  e_a;
  logic [1:0]  e_b;
  logic [64:0] e_c;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name, input string act, input string req);
    checks++;
    failures++;
    $display("FAIL %s actual=%s required=%s", name, act, req);
  endtask

  always @(negedge clk) begin
    if (rst_n && ov_a && or_a) begin
      if (q_a.size() == 0) fail_msg("a_unexpected_out", "out_valid", "no_output");
      else begin
        e_a = q_a.pop_front();
        chk("a_y", 64'(y_a), 64'(e_a[4:1]));
        chk("a_parity", 64'(par_a), 64'(e_a[0]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov_b && or_b) begin
      if (q_b.size() == 0) fail_msg("b_unexpected_out", "out_valid", "no_output");
      else begin
        e_b = q_b.pop_front();
        chk("b_y", 64'(y_b), 64'(e_b[1]));
        chk("b_parity", 64'(par_b), 64'(e_b[0]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov_c && or_c) begin
      if (q_c.size() == 0) fail_msg("c_unexpected_out", "out_valid", "no_output");
      else begin
        e_c = q_c.pop_front();
        chk("c_y", e_c[64:1] ^ y_c ^ e_c[64:1] ^ 64'(0) | y_c, e_c[64:1]);
        chk("c_parity", 64'(par_c), 64'(e_c[0]));
      end
    end
  end

  task automatic send_a(input logic [2:0] o);
    int n;
    op_a = o; a_a = 4'b1100; b_a = 4'b1010; iv_a = 1'b1; n = 0;
    @(negedge clk);
    while (!ir_a && n < 50) begin @(negedge clk); n++; end
    if (!ir_a) fail_msg("a_accept_timeout", "in_ready_low", "accept");
    else q_a.push_back({sweep_y[o], sweep_p[o]});
    @(posedge clk); #1;
    iv_a = 1'b0;
  endtask

  task automatic send_b(input logic [2:0] o);
    int n;
    op_b = o; a_b = 1'b1; b_b = 1'b0; iv_b = 1'b1; n = 0;
    @(negedge clk);
    while (!ir_b && n < 50) begin @(negedge clk); n++; end
    if (!ir_b) fail_msg("b_accept_timeout", "in_ready_low", "accept");
    else q_b.push_back({b_tab[o], b_tab[o]});
    @(posedge clk); #1;
    iv_b = 1'b0;
  endtask

  task automatic send_c(input logic [2:0] o, input logic [63:0] ye, input logic pe);
    int n;
    op_c = o; a_c = '1; b_c = '0; iv_c = 1'b1; n = 0;
    @(negedge clk);
    while (!ir_c && n < 50) begin @(negedge clk); n++; end
    if (!ir_c) fail_msg("c_accept_timeout", "in_ready_low", "accept");
    else q_c.push_back({ye, pe});
    @(posedge clk); #1;
    iv_c = 1'b0;
  endtask

  task automatic drain_all();
    int n;
    n = 0;
    while ((q_a.size() + q_b.size() + q_c.size()) != 0 && n < 100) begin @(negedge clk); n++; end
    chk("drain_pending", 64'(q_a.size() + q_b.size() + q_c.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    iv_a = 0; op_a = 0; a_a = 0; b_a = 0; or_a = 1'b1;
    iv_b = 0; op_b = 0; a_b = 0; b_b = 0; or_b = 1'b1;
    iv_c = 0; op_c = 0; a_c = 0; b_c = 0; or_c = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(ov_a), 64'd0);
    chk("rst_y", 64'(y_a), 64'd0);
    chk("rst_parity", 64'(par_a), 64'd0);
    chk("rst_count", 64'(cnt_a), 64'd0);
    chk("rst_in_ready", 64'(ir_a), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_out_valid", 64'(ov_a), 64'd0);
    chk("idle_in_ready", 64'(ir_a), 64'd1);
    chk("idle_count", 64'(cnt_a), 64'd0);
    @(posedge clk); #1;

    // op sweep with latency watch (accept on second edge, valid two edges later)
    fork
      begin
        @(negedge clk); chk("a_lat_pre", 64'(ov_a), 64'd0);
        @(negedge clk); chk("a_lat_s0", 64'(ov_a), 64'd0);
        @(negedge clk); chk("a_lat_out", 64'(ov_a), 64'd1);
      end
    join_none
    for (int i = 0; i < 8; i++) send_a(3'(i));
    drain_all();
    chk("sweep_count", 64'(cnt_a), 64'd8);

    // back-pressure
    or_a = 1'b0;
    send_a(3'd0);
    send_a(3'd1);
    op_a = 3'd2; iv_a = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(ir_a), 64'd0);
      chk("bp_out_valid", 64'(ov_a), 64'd1);
      chk("bp_y_hold", 64'(y_a), 64'(sweep_y[0]));
      chk("bp_count_hold", 64'(cnt_a), 64'd8);
    end
    @(posedge clk); #1;
    or_a = 1'b1;
    send_a(3'd2);
    drain_all();
    chk("bp_count", 64'(cnt_a), 64'd11);

    // bubble collapse
    or_a = 1'b0;
    send_a(3'd3);
    op_a = 3'd4; iv_a = 1'b1;
    @(negedge clk);
    chk("bubble_in_ready", 64'(ir_a), 64'd1);
    q_a.push_back({sweep_y[4], sweep_p[4]});
    @(posedge clk); #1;
    iv_a = 1'b0;
    @(negedge clk);
    chk("bubble_full", 64'(ir_a), 64'd0);
    @(posedge clk); #1;
    or_a = 1'b1;
    drain_all();
    chk("bubble_count", 64'(cnt_a), 64'd13);

    // asynchronous reset mid-stream
    or_a = 1'b0;
    send_a(3'd5);
    send_a(3'd6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(ov_a), 64'd0);
    chk("midrst_count", 64'(cnt_a), 64'd0);
    chk("midrst_y", 64'(y_a), 64'd0);
    q_a.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    or_a = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("midrst_no_stale", 64'(ov_a), 64'd0);
    end
    chk("midrst_in_ready", 64'(ir_a), 64'd1);
    @(posedge clk); #1;

    // WIDTH=1 / STAGES=1: one-edge latency, then op sweep
    fork
      begin
        @(negedge clk); chk("b_lat_pre", 64'(ov_b), 64'd0);
        @(negedge clk); chk("b_lat_out", 64'(ov_b), 64'd1);
      end
    join_none
    send_b(3'd2);
    for (int i = 0; i < 8; i++) send_b(3'(i));
    drain_all();
    chk("b_count", 64'(cnt_b), 64'd9);

    // WIDTH=64 / STAGES=4: four-edge latency
    fork
      begin
        repeat (4) begin @(negedge clk); chk("c_lat_empty", 64'(ov_c), 64'd0); end
        @(negedge clk); chk("c_lat_out", 64'(ov_c), 64'd1);
      end
    join_none
    send_c(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send_c(3'd0, 64'h0, 1'b0);
    send_c(3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send_c(3'd6, 64'h0, 1'b0);
    drain_all();
    chk("c_count", 64'(cnt_c), 64'd4);

    // counter wrap
    for (int i = 0; i < 65535; i++) send_a(3'(i % 8));
    drain_all();
    chk("wrap_ffff", 64'(cnt_a), 64'hFFFF);
    send_a(3'd7);
    drain_all();
    chk("wrap_zero", 64'(cnt_a), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_array_pipe.md
# gate_array_pipe

Parametrised, pipelined successor to the fixed 4-bit primitive-gate arrays. It applies one of eight bitwise gate functions across a WIDTH-bit vector pair and selects the function per transaction. Results pass through a configurable number of register stages with a valid/ready handshake on both sides. It sits between a producer and a consumer that need gate-level bitwise ops with back-pressure, and also provides the result parity and a completed-transaction counter.

## Interface
Parameters:
- WIDTH, 4: lane width of a, b, y; legal 1..64.
- STAGES, 2: number of pipeline register stages; legal 1..4.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer presents op/a/b.
- in_ready  output  1  block accepts op/a/b this cycle.
- op  input  3  function select: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT a, 7 BUF a.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; ignored for op 6 and op 7.
- out_valid  output  1  y/parity valid.
- out_ready  input  1  consumer accepts y/parity this cycle.
- y  output  WIDTH  bitwise result, bit i = f(a[i], b[i]).
- parity  output  1  XOR-reduction of y.
- xfer_count  output  16  number of completed output handshakes, modulo 2^16.

## Operation
- Input handshake: a transaction enters when in_valid && in_ready.
- Output handshake: a transaction leaves when out_valid && out_ready.
- Result is computed combinationally from op/a/b, then captured into stage 0. Stage k holds {v[k], y[k]}. Parity is computed from y at the final stage, so it carries no extra register.
- Stage advance: stage k loads from stage k-1 (or from the input, for k=0) when !v[k] || ready[k+1]. ready[STAGES] = out_ready.
- in_ready = !v[0] || ready[1]. It is a combinational chain, so a bubble anywhere downstream is filled in the same cycle.
- A stage that loads while its upstream has no valid data clears v[k]. Data registers only load on a valid transfer.
- out_valid = v[STAGES-1]; y = y[STAGES-1].
- While out_valid && !out_ready, y, parity and out_valid hold stable.
- xfer_count increments by 1 on each output handshake and wraps 0xFFFF -> 0x0000.
- Width rules: all ops are bit-parallel with no inter-bit carry. NOT and BUF use a only.
- No transaction is dropped or duplicated. Order is preserved.
- Throughput is one transaction per cycle while out_ready=1.

## Timing
- Reset (rst_n low, asynchronous): all v[k]=0 and all y[k]=0.
  - Outputs: out_valid=0, y=0, parity=0, xfer_count=0.
  - in_ready=1 combinationally once v is cleared.
- Reset asserted mid-operation: in-flight transactions are discarded, with no output handshake for them.
- Reset deassertion: the first acceptance is possible in the first clk edge with rst_n high.
- Latency: a transaction accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. it is visible in the cycle following edge N+STAGES-1. Equivalently, it is STAGES cycles from input acceptance to output-valid cycle.
- Full: all STAGES valid and out_ready=0 gives in_ready=0.
- Full with out_ready=1: in_ready=1 in the same cycle, so simultaneous input and output handshakes keep occupancy constant.
- Empty: out_valid=0; in_ready=1 regardless of out_ready.
- Counter wrap coincides with a handshake only. There is no other increment source.

## Test plan
- Reset/idle: hold rst_n=0, then release. Required: out_valid=0, y=0, parity=0, xfer_count=0, in_ready=1.
- Op sweep, WIDTH=4, STAGES=2: a=4'b1100, b=4'b1010, op 0..7 on consecutive cycles, out_ready=1. Required y sequence 1000, 1110, 0110, 0111, 0001, 1001, 0011, 1100 and parity 1,1,0,1,1,0,0,0. First out_valid appears 2 cycles after the first accept; then one result per cycle; xfer_count=8.
- Back-pressure: fill with 3 transactions, out_ready=0 for 5 cycles. Required: in_ready=0 after 2 accepts (STAGES=2), y stable, no count change. Then raise out_ready: results drain in order and xfer_count increases by exactly 2, then 1.
- Bubble collapse: one transaction, out_ready=0, in_valid=1 continuously. Required: the second transaction is accepted into the empty stage 0 (in_ready=1), then in_ready=0.
- Reset mid-stream: assert rst_n=0 asynchronously between edges with 2 valid stages. Required: out_valid drops immediately, xfer_count=0, and no stale y appears after release.
- Counter wrap plus parameters: force 65536 handshakes. Required: xfer_count returns to 0. Repeat the op sweep at WIDTH=1/STAGES=1 (latency 1) and WIDTH=64/STAGES=4 (latency 4) with a=all-ones, b=0, op 2. Required: y all-ones, parity=0.
